edge_window_sequencer: RTL and testbench

- Frame-level controller for the Sobel edge-detection datapath.
- Walks the source image in 3-row x 4-column windows. For each window it:
  - issues 12 pixel-read requests toward the AHB master;
  - clears and fills the 12-byte window buffer;
  - triggers the edge computation;
  - issues two pixel-write requests for the two results.
- Sits between the slave register file (start/geometry/addresses) and the master/buffer/edge-detection datapath.

---
 rtl/edge_window_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_edge_window_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_sequencer.sv
// Frame-level controller for the Sobel datapath: walks the image in 3x4 windows,
// fetching 12 pixels, triggering the edge computation and writing two results.
module edge_window_sequencer #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic [ADDR_W-1:0] source_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              buffer_clear,
  output logic              calc_start,
  input  logic              calc_done,
  input  logic [7:0]        result1,
  input  logic [7:0]        result2,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_CALC, S_WRITE1, S_WRITE2, S_ADVANCE, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  length_q, length_d;
  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [3:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] src_row_q, src_row_d;
  logic [ADDR_W-1:0] dst_row_q, dst_row_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        res1_q, res1_d;
  logic [7:0]        res2_q, res2_d;
  logic              calc_issued_q, calc_issued_d;
  logic              cfg_err_q, cfg_err_d;

  // One extra bit keeps the window-fits comparisons free of wrap-around.
  logic [DIM_W:0] c_next_ext, c_last_ext, r_next_ext, r_last_ext;
  assign c_next_ext = {1'b0, c_q} + (DIM_W+1)'(2);
  assign c_last_ext = {1'b0, width_q} - (DIM_W+1)'(4);
  assign r_next_ext = {1'b0, r_q} + (DIM_W+1)'(1);
  assign r_last_ext = {1'b0, length_q} - (DIM_W+1)'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      width_q       <= '0;
      length_q      <= '0;
      r_q           <= '0;
      c_q           <= '0;
      idx_q         <= '0;
      src_row_q     <= '0;
      dst_row_q     <= '0;
      rd_addr_q     <= '0;
      res1_q        <= '0;
      res2_q        <= '0;
      calc_issued_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      length_q      <= length_d;
      r_q           <= r_d;
      c_q           <= c_d;
      idx_q         <= idx_d;
      src_row_q     <= src_row_d;
      dst_row_q     <= dst_row_d;
      rd_addr_q     <= rd_addr_d;
      res1_q        <= res1_d;
      res2_q        <= res2_d;
      calc_issued_q <= calc_issued_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    length_d      = length_q;
    r_d           = r_q;
    c_d           = c_q;
    idx_d         = idx_q;
    src_row_d     = src_row_q;
    dst_row_d     = dst_row_q;
    rd_addr_d     = rd_addr_q;
    res1_d        = res1_q;
    res2_d        = res2_q;
    calc_issued_d = calc_issued_q;
    cfg_err_d     = 1'b0;
    rd_req        = 1'b0;
    rd_addr       = '0;
    buffer_clear  = 1'b0;
    calc_start    = 1'b0;
    wr_req        = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (width >= DIM_W'(4) && !width[0] && length >= DIM_W'(3)) begin
            width_d   = width;
            length_d  = length;
            src_row_d = source_addr;
            dst_row_d = dest_addr;
            r_d       = '0;
            c_d       = '0;
            state_d   = S_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        buffer_clear = 1'b1;
        idx_d        = '0;
        rd_addr_d    = src_row_q + ADDR_W'(c_q);
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        rd_req        = 1'b1;
        rd_addr       = rd_addr_q;
        calc_issued_d = 1'b0;
        if (rd_done) begin
          idx_d = idx_q + 4'd1;
          // End of a 4-pixel row: jump to the same column one image row down.
          if (idx_q[1:0] == 2'd3)
            rd_addr_d = rd_addr_q + ADDR_W'(width_q) - ADDR_W'(3);
          else
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (idx_q == 4'd11)
            state_d = S_CALC;
        end
      end
      S_CALC: begin
        calc_start    = !calc_issued_q;
        calc_issued_d = 1'b1;
        if (calc_done) begin
          res1_d  = result1;
          res2_d  = result2;
          state_d = S_WRITE1;
        end
      end
      S_WRITE1: begin
        wr_req  = 1'b1;
        wr_addr = dst_row_q + ADDR_W'(c_q);
        wr_data = res1_q;
        if (wr_done) state_d = S_WRITE2;
      end
      S_WRITE2: begin
        wr_req  = 1'b1;
        wr_addr = dst_row_q + ADDR_W'(c_q) + ADDR_W'(1);
        wr_data = res2_q;
        if (wr_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (c_next_ext <= c_last_ext) begin
          c_d     = c_q + DIM_W'(2);
          state_d = S_CLEAR;
        end else if (r_next_ext <= r_last_ext) begin
          c_d       = '0;
          r_d       = r_q + DIM_W'(1);
          src_row_d = src_row_q + ADDR_W'(width_q);
          dst_row_d = dst_row_q + ADDR_W'(width_q) - ADDR_W'(2);
          state_d   = S_CLEAR;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Directed self-checking bench for edge_window_sequencer with handshake responders
// and a negedge monitor that logs every accepted read/write.
module tb_edge_window_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] width, length;
  logic [31:0] source_addr, dest_addr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_done;
  logic        buffer_clear, calc_start, calc_done;
  logic [7:0]  result1, result2;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done, busy, done, cfg_err;

  edge_window_sequencer #(.DIM_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .length(length),
    .source_addr(source_addr), .dest_addr(dest_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .buffer_clear(buffer_clear), .calc_start(calc_start), .calc_done(calc_done),
    .result1(result1), .result2(result2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stall configuration, written only by the stimulus block.
  int rd_stall_elem = -1;
  int rd_stall_cfg  = 0;
  int wr_stall_cfg  = 0;
  logic log_rst = 1'b0;

  // Responder: zero-wait handshakes unless a stall is configured.
  int rd_elem = 0, rd_stall_used = 0, wr_phase = 0, wr_stall_used = 0, win_idx = 0;
  always @(negedge clk) begin
    if (!busy) begin
      rd_elem = 0; rd_stall_used = 0; wr_phase = 0; wr_stall_used = 0; win_idx = 0;
    end
    if (rd_req) begin
      if (rd_elem == rd_stall_elem && rd_stall_used < rd_stall_cfg) begin
        rd_done = 1'b0; rd_stall_used++;
      end else begin
        rd_done = 1'b1; rd_elem = (rd_elem + 1) % 12;
      end
    end else rd_done = 1'b0;
    if (wr_req) begin
      if (wr_phase == 1 && wr_stall_used < wr_stall_cfg) begin
        wr_done = 1'b0; wr_stall_used++;
      end else begin
        wr_done = 1'b1; wr_phase = 1 - wr_phase;
      end
    end else wr_done = 1'b0;
    calc_done = calc_start;
    result1   = 8'hA0 + 8'(win_idx);
    result2   = 8'h50 + 8'(win_idx);
    if (calc_start) win_idx++;
  end

  // Monitor
  logic [31:0] rd_log[$];
  logic [31:0] wr_a_log[$];
  logic [7:0]  wr_d_log[$];
  int cycle = 0, done_cnt = 0, cfg_cnt = 0, clear_cnt = 0, busy_cycles = 0;
  int start_cycle = 0, done_cycle = 0, overlap = 0, unstable = 0, rd_wait = 0, wr_wait = 0;
  logic prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
  logic [31:0] prev_rd_addr = '0, prev_wr_addr = '0;
  logic [7:0]  prev_wr_data = '0;
  always @(negedge clk) begin
    #1;
    cycle++;
    if (log_rst) begin
      rd_log.delete(); wr_a_log.delete(); wr_d_log.delete();
      done_cnt = 0; cfg_cnt = 0; clear_cnt = 0; busy_cycles = 0; overlap = 0;
      unstable = 0; rd_wait = 0; wr_wait = 0; prev_rd_wait = 1'b0; prev_wr_wait = 1'b0;
    end else begin
      if (start && !busy) start_cycle = cycle;
      if (rd_req && rd_done) rd_log.push_back(rd_addr);
      if (wr_req && wr_done) begin wr_a_log.push_back(wr_addr); wr_d_log.push_back(wr_data); end
      if (rd_req && !rd_done) rd_wait++;
      if (wr_req && !wr_done) wr_wait++;
      if (prev_rd_wait && (!rd_req || rd_addr != prev_rd_addr)) unstable++;
      if (prev_wr_wait && (!wr_req || wr_addr != prev_wr_addr || wr_data != prev_wr_data)) unstable++;
      prev_rd_wait = rd_req && !rd_done; prev_rd_addr = rd_addr;
      prev_wr_wait = wr_req && !wr_done; prev_wr_addr = wr_addr; prev_wr_data = wr_data;
      if (done) begin done_cnt++; done_cycle = cycle; end
      if (cfg_err) cfg_cnt++;
      if (buffer_clear) clear_cnt++;
      if (rd_req && wr_req) overlap++;
      if (busy) busy_cycles++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk); log_rst = 1'b1;
    @(negedge clk); log_rst = 1'b0;
  endtask

  task automatic pulse_start(input int w, input int l, input int s, input int d);
    width = 16'(w); length = 16'(l); source_addr = 32'(s); dest_addr = 32'(d);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); #2; n++; end
    check({tag, "_timeout"}, int'(done_cnt != 0), 1);
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return rd_addr | wr_addr | 32'(wr_data) |
           32'({rd_req, buffer_clear, calc_start, wr_req, busy, done, cfg_err});
  endfunction

  initial begin
    int n;
    int bw[3];
    int bl[3];
    rst = 1'b1; start = 1'b0; width = '0; length = '0; source_addr = '0; dest_addr = '0;
    rd_done = 1'b0; wr_done = 1'b0; calc_done = 1'b0; result1 = '0; result2 = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outs(), 0);

    // Smallest frame, zero-wait.
    clear_logs();
    pulse_start(4, 3, 32'h1000, 32'h2000);
    wait_done("f43");
    check("f43_rd_count", rd_log.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < rd_log.size()) check($sformatf("f43_rd_addr[%0d]", i), rd_log[i], 32'h1000 + i);
    check("f43_wr_count", wr_a_log.size(), 2);
    if (wr_a_log.size() == 2) begin
      check("f43_wr_addr0", wr_a_log[0], 32'h2000);
      check("f43_wr_addr1", wr_a_log[1], 32'h2001);
      check("f43_wr_data0", wr_d_log[0], 8'hA0);
      check("f43_wr_data1", wr_d_log[1], 8'h50);
    end
    check("f43_done_once", done_cnt, 1);
    check("f43_start_to_done", done_cycle - start_cycle + 1, 19);
    check("f43_busy_cycles", busy_cycles, 18);
    check("f43_overlap", overlap, 0);

    // 6x4 frame: four windows.
    clear_logs();
    pulse_start(6, 4, 0, 32'h100);
    wait_done("f64");
    check("f64_clears", clear_cnt, 4);
    check("f64_rd_count", rd_log.size(), 48);
    if (rd_log.size() == 48) begin
      check("f64_w1_first", rd_log[12], 2);
      check("f64_w1_last", rd_log[23], 17);
      check("f64_w2_first", rd_log[24], 6);
      check("f64_w2_elem4", rd_log[28], 12);
      check("f64_w3_first", rd_log[36], 8);
      check("f64_w3_last", rd_log[47], 23);
    end
    check("f64_wr_count", wr_a_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < wr_a_log.size()) begin
        check($sformatf("f64_wr_addr[%0d]", k), wr_a_log[k], 32'h100 + k);
        check($sformatf("f64_wr_data[%0d]", k), wr_d_log[k],
              (k % 2 == 0) ? 8'hA0 + k / 2 : 8'h50 + k / 2);
      end
    check("f64_done_once", done_cnt, 1);

    // Stalled handshakes.
    rd_stall_elem = 5; rd_stall_cfg = 3; wr_stall_cfg = 2;
    clear_logs();
    pulse_start(4, 3, 32'h1000, 32'h2000);
    wait_done("stall");
    rd_stall_elem = -1; rd_stall_cfg = 0; wr_stall_cfg = 0;
    check("stall_rd_wait", rd_wait, 3);
    check("stall_wr_wait", wr_wait, 2);
    check("stall_unstable", unstable, 0);
    check("stall_rd_count", rd_log.size(), 12);
    if (rd_log.size() == 12) begin
      check("stall_rd5", rd_log[5], 32'h1005);
      check("stall_rd6", rd_log[6], 32'h1006);
    end
    if (wr_a_log.size() == 2) begin
      check("stall_wr_addr1", wr_a_log[1], 32'h2001);
      check("stall_wr_data1", wr_d_log[1], 8'h50);
    end else check("stall_wr_count", wr_a_log.size(), 2);

    // Rejected geometries.
    bw = '{5, 2, 4};
    bl = '{3, 3, 2};
    for (int t = 0; t < 3; t++) begin
      clear_logs();
      pulse_start(bw[t], bl[t], 32'h1000, 32'h2000);
      repeat (4) @(negedge clk);
      check($sformatf("bad%0d_cfg_err", t), cfg_cnt, 1);
      check($sformatf("bad%0d_busy", t), busy_cycles, 0);
      check($sformatf("bad%0d_reads", t), rd_log.size(), 0);
    end

    // Start during LOAD with a different width must be ignored.
    clear_logs();
    pulse_start(4, 3, 32'h1000, 32'h2000);
    n = 0;
    while (rd_log.size() < 5 && n < 200) begin @(negedge clk); n++; end
    pulse_start(8, 3, 32'h1000, 32'h2000);
    wait_done("restart_ign");
    check("ign_clears", clear_cnt, 1);
    check("ign_rd_count", rd_log.size(), 12);
    if (rd_log.size() == 12) check("ign_rd_last", rd_log[11], 32'h100B);
    check("ign_done_once", done_cnt, 1);
    check("ign_cfg_err", cfg_cnt, 0);

    // Asynchronous reset during LOAD of the second window.
    clear_logs();
    pulse_start(6, 4, 0, 32'h100);
    n = 0;
    while (!(clear_cnt == 2 && rd_log.size() >= 15) && n < 300) begin @(negedge clk); #2; n++; end
    check("rst_reached_w1", rd_log.size() >= 15 ? 1 : 0, 1);
    #1 rst = 1'b1;
    #1 check("midrst_outputs", all_outs(), 0);
    @(negedge clk); rst = 1'b0;
    clear_logs();
    pulse_start(6, 4, 32'h40, 32'h100);
    wait_done("after_rst");
    check("ar_rd_count", rd_log.size(), 48);
    if (rd_log.size() == 48) begin
      check("ar_rd_first", rd_log[0], 32'h40);
      check("ar_rd_11", rd_log[11], 32'h4F);
    end
    if (wr_a_log.size() > 0) check("ar_wr_first", wr_a_log[0], 32'h100);
    else check("ar_wr_count", wr_a_log.size(), 8);
    check("ar_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
